dmem_apb_arbiter: RTL and testbench
===================================

# dmem_apb_arbiter

Two-requester arbiter and APB-style sequencer in front of the data-memory bank. Requester 0 is the pipeline LSU, requester 1 is the debug/DMA port. The block grants one request at a time round-robin, rejects accesses the bank cannot serve, drives the bank through a setup and access phase, and returns registered read data with a one-cycle response pulse.

## Interface
- `DMEM_ADDR`, default 6: bank word-address width; requester byte address is `DMEM_ADDR+2` bits.
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: reset, asynchronous, active-low.
- `req_valid_i` in, [1:0]: request valid, one bit per requester.
- `req_ready_o` out, [1:0]: request accepted on a cycle where valid and ready are both high.
- `req_addr_i` in, [1:0][DMEM_ADDR+1:0]: byte address.
- `req_write_i` in, [1:0]: 1 = store, 0 = load.
- `req_funct_i` in, [1:0][2:0]: funct3 code.
- `req_wdata_i` in, [1:0][31:0]: store data, LSB-aligned.
- `rsp_valid_o` out, [1:0]: one-cycle response pulse to the granted requester.
- `rsp_err_o` out, 1: response is an error; no bank access occurred.
- `rsp_rdata_o` out, 32: load data, already extended; 0 for stores and errors.
- `paddr_o` out, DMEM_ADDR: bank word address.
- `penable_o` out, 1: bank access phase.
- `pwrite_o` out, 1: bank write.
- `pwdata_o` out, 32: bank write data.
- `pfunct_code_o` out, 3: bank funct code.
- `prdata_i` in, 32: bank read data, valid while `penable_o` is high.

## Operation
- FSM has three states: IDLE, SETUP, ACCESS.
- **IDLE**
  - `req_ready_o` = grant vector; at most one bit is set.
  - On accept, latch addr, write, funct and wdata of the winner, plus the winner index.
  - Legal request: go to SETUP.
  - Illegal request: stay in IDLE and schedule an error response for the next cycle.
- **SETUP**
  - `paddr_o` = `addr[DMEM_ADDR+1:2]`.
  - Funct, write and wdata are driven from the latch.
  - `penable_o`=0.
  - Next state is ACCESS.
- **ACCESS**
  - Same outputs as SETUP, with `penable_o`=1. The bank commits a write at the end of this cycle.
  - For a load, capture `prdata_i` into the response register.
  - Next state is IDLE.
- **Legality**
  - Legal funct codes: 0 (B), 1 (H), 2 (W), 4 (BU), 5 (HU).
  - Stores accept only 0, 1 or 2.
  - The bank uses fixed lanes, so `addr[1:0]` must be 0 for every size.
  - Anything else is an error: `rsp_err_o`=1 and nothing is driven to the bank.
- **Arbitration**
  - `last_grant` is a 1-bit register.
  - If only one requester is valid, it wins.
  - If both are valid, the requester ≠ `last_grant` wins.
  - `last_grant` updates on every accept, including error accepts.
- **Response**
  - `rsp_valid_o[idx]` pulses exactly one cycle, on the first IDLE cycle after ACCESS, or on the cycle after an error accept.
  - `rsp_rdata_o` and `rsp_err_o` hold their values until the next response.
- **Back-to-back**
  - A new accept may occur in the same cycle `rsp_valid_o` is high.
- **Requester obligations**
  - A requester holds its valid and payload stable until ready.
  - The arbiter never drops or reorders a request of one requester.

## Timing
- Legal access: accept at edge T0, SETUP in T1, ACCESS in T2, `rsp_valid_o` high in T3.
  - Latency is 3 cycles.
  - Peak rate is one transaction per 3 cycles.
- Error: accept at T0, `rsp_valid_o` and `rsp_err_o` high in T1.
  - Peak rate is one error per cycle.
- `req_ready_o` is 0 in SETUP and ACCESS.
- Ready depends combinationally on `req_valid_i` and state only.
- Reset values:
  - state=IDLE, `last_grant`=1 (requester 0 wins the first tie).
  - `rsp_valid_o`=0, `rsp_err_o`=0, `rsp_rdata_o`=0.
  - `paddr_o`=0, `penable_o`=0, `pwrite_o`=0, `pwdata_o`=0, `pfunct_code_o`=0.
- Bank outputs are 0 in IDLE.
- Reset asserted in SETUP or ACCESS:
  - Immediately forces `penable_o`=0, so no write occurs.
  - The pending response is discarded.

## Structure
- Package `dmem_arb_pkg` contains:
  - State enum `arb_state_e` (IDLE, SETUP, ACCESS).
  - Funct localparams `F_B=0`, `F_H=1`, `F_W=2`, `F_BU=4`, `F_HU=5`.
  - Packed struct `dmem_req_t` holding addr, write, funct and wdata.
  - Function `is_legal(write, funct, off)`.
- Sub-module `dmem_rr_arb` is the 2-way round-robin grant with the `last_grant` register.
- The top level holds the FSM, request latch and response register.

## Test plan
- Reset, then req0 stores word 0xDEADBEEF at addr 0x08 -> bank sees `paddr_o`=2, `penable_o`=1 for exactly one cycle, and `rsp_valid_o`=2'b01 three cycles after accept; a following LW from 0x08 returns 0xDEADBEEF.
- LB, LBU, LH and LHU at 0x08 with 0x0000_80F0 stored -> `rsp_rdata_o` = 0xFFFF_FFF0, 0x0000_00F0, 0xFFFF_80F0, 0x0000_80F0.
- Both requesters valid continuously after reset -> grants alternate 0,1,0,1; no requester is granted twice in a row; each response pulse goes to the matching bit.
- Illegal requests:
  - LW at 0x0A -> `rsp_err_o`=1 one cycle after accept, and `penable_o` never rises.
  - Store with funct 4 -> error response.
  - funct 3 -> error response.
- Reset asserted during ACCESS of a store to 0x04 -> `penable_o` drops asynchronously; a subsequent LW from 0x04 returns the old value; `rsp_valid_o` stays 0.
- Response and new accept in the same cycle -> next SETUP starts the following cycle with no idle gap.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types, funct codes and helpers for the data-memory arbiter.
// Imported by the arbiter top, the round-robin grant and the bench.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_e;

    localparam logic [2:0] F_B  = 3'd0;
    localparam logic [2:0] F_H  = 3'd1;
    localparam logic [2:0] F_W  = 3'd2;
    localparam logic [2:0] F_BU = 3'd4;
    localparam logic [2:0] F_HU = 3'd5;

    // Byte address is held zero-extended so the latch type does not
    // depend on the bank size parameter.
    localparam int unsigned REQ_AW = 32;

    typedef struct packed {
        logic [REQ_AW-1:0] addr;
        logic              write;
        logic [2:0]        funct;
        logic [31:0]       wdata;
    } dmem_req_t;

    function automatic logic is_legal(
        input logic       write,
        input logic [2:0] funct,
        input logic [1:0] off
    );
        logic ok;
        unique case (funct)
            F_B, F_H, F_W: ok = 1'b1;
            F_BU, F_HU:    ok = ~write;
            default:       ok = 1'b0;
        endcase
        return ok && (off == 2'b00);
    endfunction

    // Lanes are fixed, so sub-word loads always come from the low lanes.
    function automatic logic [31:0] load_ext(
        input logic [2:0]  funct,
        input logic [31:0] d
    );
        logic [31:0] r;
        unique case (1'b1)
            funct == F_B:  r = {{24{d[7]}}, d[7:0]};
            funct == F_BU: r = {24'h0, d[7:0]};
            funct == F_H:  r = {{16{d[15]}}, d[15:0]};
            funct == F_HU: r = {16'h0, d[15:0]};
            default:       r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Requester-side handshake bundle of the data-memory arbiter.
// master = requesters (LSU / debug-DMA), slave = arbiter.
interface dmem_arb_if #(
    parameter int unsigned DMEM_ADDR = 6
) ();
    logic [1:0]                 req_valid_i;
    logic [1:0]                 req_ready_o;
    logic [1:0][DMEM_ADDR+1:0]  req_addr_i;
    logic [1:0]                 req_write_i;
    logic [1:0][2:0]            req_funct_i;
    logic [1:0][31:0]           req_wdata_i;
    logic [1:0]                 rsp_valid_o;
    logic                       rsp_err_o;
    logic [31:0]                rsp_rdata_o;

    modport master (
        output req_valid_i, req_addr_i, req_write_i,
        output req_funct_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_write_i,
        input  req_funct_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o
    );
endinterface

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin grant holding the last-grant register.
// Ports: i_valid (requests), i_en (may grant), o_grant (one-hot).
module dmem_rr_arb (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] i_valid,
    input  logic       i_en,
    output logic [1:0] o_grant
);

    logic r_last;

    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            unique case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_last <= 1'b1;
        else if (|(i_valid & o_grant))
            r_last <= o_grant[1];
    end

endmodule

// File: rtl/dmem_apb_arbiter.sv
// Round-robin arbiter + setup/access sequencer for the data-memory bank.
// Ports: clk_i, rst_ni, bus (requester handshake), p* bank signals.
module dmem_apb_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DMEM_ADDR = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    dmem_arb_if.slave            bus,
    output logic [DMEM_ADDR-1:0] paddr_o,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [31:0]          pwdata_o,
    output logic [2:0]           pfunct_code_o,
    input  logic [31:0]          prdata_i
);

    arb_state_e  r_state;
    dmem_req_t   r_req;
    logic        r_idx;
    logic        r_bus;
    logic        r_penable;
    logic [1:0]  r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic [1:0]  w_grant;
    logic        w_accept;
    logic        w_win;
    logic        w_legal;
    dmem_req_t   w_sel;
    logic        w_unused;

    dmem_rr_arb u_arb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_valid (bus.req_valid_i),
        .i_en    (r_state == IDLE),
        .o_grant (w_grant)
    );

    assign bus.req_ready_o = w_grant;
    assign w_accept = |(bus.req_valid_i & w_grant);
    assign w_win    = w_grant[1];

    always_comb begin
        w_sel.addr  = REQ_AW'(bus.req_addr_i[w_win]);
        w_sel.write = bus.req_write_i[w_win];
        w_sel.funct = bus.req_funct_i[w_win];
        w_sel.wdata = bus.req_wdata_i[w_win];
    end

    assign w_legal = is_legal(w_sel.write, w_sel.funct, w_sel.addr[1:0]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_idx       <= 1'b0;
            r_bus       <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 2'b00;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_idx <= w_win;
                        r_req <= w_sel;
                        if (w_legal) begin
                            r_state <= SETUP;
                            r_bus   <= 1'b1;
                        end else begin
                            // Rejected: answer next cycle, bank untouched.
                            r_rsp_valid <= w_win ? 2'b10 : 2'b01;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    r_state     <= IDLE;
                    r_penable   <= 1'b0;
                    r_bus       <= 1'b0;
                    r_rsp_valid <= r_idx ? 2'b10 : 2'b01;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= r_req.write ? 32'h0
                                 : load_ext(r_req.funct, prdata_i);
                end
                default: begin
                    r_state   <= IDLE;
                    r_penable <= 1'b0;
                    r_bus     <= 1'b0;
                end
            endcase
        end
    end

    // Bank signals are zero whenever no transfer is in flight.
    assign paddr_o       = r_bus ? r_req.addr[DMEM_ADDR+1:2] : '0;
    assign pwrite_o      = r_bus & r_req.write;
    assign pwdata_o      = r_bus ? r_req.wdata : 32'h0;
    assign pfunct_code_o = r_bus ? r_req.funct : 3'h0;
    assign penable_o     = r_penable;

    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.rsp_rdata_o = r_rsp_rdata;

    // Offset bits were already checked at accept; upper bits are zero.
    assign w_unused = ^{r_req.addr[1:0], r_req.addr[REQ_AW-1:DMEM_ADDR+2]};

endmodule

// File: tb/tb_dmem_apb_arbiter.sv
// Scoreboard bench for dmem_apb_arbiter with a behavioural bank.
// Directed vectors; a monitor checks every response pulse.
module tb_dmem_apb_arbiter;
    import dmem_arb_pkg::*;

    typedef struct {
        logic [1:0]  v;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  paddr;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [2:0]  pfunct;
    logic [31:0] prdata;

    logic [31:0] mem [0:63];
    exp_t        sb [$];
    int          pen_hist [$];
    int          n_tests;
    int          n_fail;
    int          pen_cnt;
    int          cyc;

    dmem_arb_if #(.DMEM_ADDR(6)) bus ();

    dmem_apb_arbiter #(.DMEM_ADDR(6)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus           (bus),
        .paddr_o       (paddr),
        .penable_o     (penable),
        .pwrite_o      (pwrite),
        .pwdata_o      (pwdata),
        .pfunct_code_o (pfunct),
        .prdata_i      (prdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign prdata = mem[paddr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (penable && pwrite) begin
            case (pfunct)
                F_B:     mem[paddr][7:0]  <= pwdata[7:0];
                F_H:     mem[paddr][15:0] <= pwdata[15:0];
                default: mem[paddr]       <= pwdata;
            endcase
        end
    end

    always @(negedge clk) begin
        if (penable) begin
            pen_cnt = pen_cnt + 1;
            pen_hist.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.rsp_valid_o != 2'b00) begin
            n_tests = n_tests + 1;
            if (sb.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL rsp_unexpected got v=%b err=%b rd=%h",
                         bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o);
            end else begin
                e = sb.pop_front();
                if (bus.rsp_valid_o !== e.v || bus.rsp_err_o !== e.err ||
                    bus.rsp_rdata_o !== e.rd) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rsp got v=%b err=%b rd=%h exp v=%b err=%b rd=%h",
                             bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o,
                             e.v, e.err, e.rd);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic start(input int r, input logic [7:0] a, input logic w,
                         input logic [2:0] f, input logic [31:0] wd,
                         input bit chk, input logic e, input logic [31:0] rd);
        exp_t x;
        bus.req_addr_i[r]  = a;
        bus.req_write_i[r] = w;
        bus.req_funct_i[r] = f;
        bus.req_wdata_i[r] = wd;
        bus.req_valid_i[r] = 1'b1;
        if (chk) begin
            x.v   = (r == 1) ? 2'b10 : 2'b01;
            x.err = e;
            x.rd  = rd;
            sb.push_back(x);
        end
    endtask

    task automatic wait_accept(input int r, output logic [1:0] rv);
        int k;
        k = 0;
        while (!bus.req_ready_o[r] && k < 40) begin
            @(negedge clk);
            k++;
        end
        rv = bus.rsp_valid_o;
        if (!bus.req_ready_o[r]) begin
            n_tests = n_tests + 1;
            n_fail = n_fail + 1;
            $display("FAIL accept_timeout req=%0d got=0 exp=1", r);
        end
        @(posedge clk);
        #1;
        bus.req_valid_i[r] = 1'b0;
    endtask

    task automatic send(input int r, input logic [7:0] a, input logic w,
                        input logic [2:0] f, input logic [31:0] wd,
                        input bit chk, input logic e, input logic [31:0] rd);
        logic [1:0] rv;
        @(negedge clk);
        start(r, a, w, f, wd, chk, e, rd);
        wait_accept(r, rv);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        if (sb.size() != 0) begin
            n_tests = n_tests + 1;
            n_fail = n_fail + 1;
            $display("FAIL drain_timeout got=%0d pending exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        check("rst_bank", {penable, paddr, pwrite, pfunct, pwdata}, 64'h0);
        check("rst_rsp", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o},
              64'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] rv;
        int p0;
        int n;
        n_tests = 0;
        n_fail = 0;
        pen_cnt = 0;
        cyc = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        bus.req_valid_i = '0;
        bus.req_addr_i  = '0;
        bus.req_write_i = '0;
        bus.req_funct_i = '0;
        bus.req_wdata_i = '0;
        rst_n = 1'b0;
        #1;
        check("rst_async_out", {penable, bus.rsp_valid_o}, 64'h0);
        apply_reset();
        check("idle_ready", bus.req_ready_o, 64'h0);

        // SW 0xDEADBEEF @0x08 with phase-by-phase timing
        p0 = pen_cnt;
        send(0, 8'h08, 1'b1, F_W, 32'hDEAD_BEEF, 1, 1'b0, 32'h0);
        @(negedge clk);
        check("sw_setup", {penable, paddr, pwrite, pfunct, pwdata},
              {21'h0, 1'b0, 6'd2, 1'b1, 3'd2, 32'hDEAD_BEEF});
        @(negedge clk);
        check("sw_access", {penable, paddr, pwrite, pfunct, pwdata},
              {21'h0, 1'b1, 6'd2, 1'b1, 3'd2, 32'hDEAD_BEEF});
        @(negedge clk);
        check("sw_rsp_lat", {bus.rsp_valid_o, penable}, 64'b010);
        drain();
        check("sw_pen_once", pen_cnt - p0, 64'd1);
        check("idle_bank_zero", {paddr, pwrite, pfunct, pwdata}, 64'h0);

        send(0, 8'h08, 1'b0, F_W, 32'h0, 1, 1'b0, 32'hDEAD_BEEF);
        drain();

        // Sub-word loads from 0x0000_80F0
        send(1, 8'h08, 1'b1, F_W, 32'h0000_80F0, 1, 1'b0, 32'h0);
        send(0, 8'h08, 1'b0, F_B,  32'h0, 1, 1'b0, 32'hFFFF_FFF0);
        send(0, 8'h08, 1'b0, F_BU, 32'h0, 1, 1'b0, 32'h0000_00F0);
        send(1, 8'h08, 1'b0, F_H,  32'h0, 1, 1'b0, 32'hFFFF_80F0);
        send(0, 8'h08, 1'b0, F_HU, 32'h0, 1, 1'b0, 32'h0000_80F0);
        send(0, 8'h10, 1'b1, F_W, 32'hA0A0_0001, 1, 1'b0, 32'h0);
        send(1, 8'h14, 1'b1, F_W, 32'hB1B1_0002, 1, 1'b0, 32'h0);
        drain();

        // Illegal requests
        p0 = pen_cnt;
        send(0, 8'h0A, 1'b0, F_W, 32'h0, 1, 1'b1, 32'h0);
        @(negedge clk);
        check("err_lat", {bus.rsp_valid_o, bus.rsp_err_o}, 64'b011);
        send(1, 8'h08, 1'b1, F_BU, 32'h1234, 1, 1'b1, 32'h0);
        send(0, 8'h08, 1'b0, 3'd3, 32'h0, 1, 1'b1, 32'h0);
        send(1, 8'h02, 1'b1, F_H, 32'h55AA, 1, 1'b1, 32'h0);
        drain();
        check("err_no_pen", pen_cnt - p0, 64'd0);
        check("err_mem_kept", mem[2], 64'h0000_80F0);

        // Response and new accept in the same cycle
        pen_hist.delete();
        send(0, 8'h08, 1'b0, F_W, 32'h0, 1, 1'b0, 32'h0000_80F0);
        start(1, 8'h10, 1'b0, F_W, 32'h0, 1, 1'b0, 32'hA0A0_0001);
        wait_accept(1, rv);
        check("b2b_same_cycle", rv, 64'b01);
        drain();
        check("b2b_pen_cnt", pen_hist.size(), 64'd2);
        if (pen_hist.size() == 2)
            check("b2b_gap", pen_hist[1] - pen_hist[0], 64'd3);

        // Both valid from reset: grants alternate 0,1,0,1,0,1
        @(negedge clk);
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            exp_t x;
            x.v   = i[0] ? 2'b10 : 2'b01;
            x.err = 1'b0;
            x.rd  = i[0] ? 32'hB1B1_0002 : 32'hA0A0_0001;
            sb.push_back(x);
        end
        start(0, 8'h10, 1'b0, F_W, 32'h0, 0, 1'b0, 32'h0);
        start(1, 8'h14, 1'b0, F_W, 32'h0, 0, 1'b0, 32'h0);
        n = 0;
        for (int k = 0; k < 60 && n < 6; k++) begin
            if (|(bus.req_valid_i & bus.req_ready_o)) begin
                check("alt_grant", bus.req_ready_o,
                      (n % 2 == 1) ? 64'b10 : 64'b01);
                n++;
                if (n == 6) begin
                    @(posedge clk);
                    #1;
                    bus.req_valid_i = 2'b00;
                end
            end
            if (n < 6) @(negedge clk);
        end
        check("alt_count", n, 64'd6);
        bus.req_valid_i = 2'b00;
        drain();

        // Reset during ACCESS of a store aborts it
        send(0, 8'h04, 1'b1, F_W, 32'h1111_1111, 1, 1'b0, 32'h0);
        drain();
        send(0, 8'h04, 1'b1, F_W, 32'h2222_2222, 0, 1'b0, 32'h0);
        @(posedge clk);
        #2;
        check("abort_in_access", penable, 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_pen_async", penable, 64'd0);
        @(negedge clk);
        check("abort_no_rsp", bus.rsp_valid_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_rsp_quiet", bus.rsp_valid_o, 64'd0);
        end
        send(0, 8'h04, 1'b0, F_W, 32'h0, 1, 1'b0, 32'h1111_1111);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
